// File: rtl/data_island_scheduler.sv
// HDMI data-island scheduler: places preamble, guard bands and 32-cycle
// packet windows inside each line's horizontal blanking, and pops the
// upstream packet queue one cycle ahead of every packet window.
module data_island_scheduler #(
  parameter int LEAD        = 4,
  parameter int TAIL        = 22,
  parameter int MAX_PACKETS = 18,
  parameter int LEN_W       = 12
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             blank_start,
  input  logic [LEN_W-1:0] blank_len,
  input  logic             packet_pending,
  output logic             packet_pop,
  output logic             island_preamble,
  output logic             island_guard,
  output logic             data_island_period,
  output logic [4:0]       packet_count
);

  localparam int CNT_W = $clog2(LEAD + 8);
  // Whole-island fit: preamble(8) + guards(4) + one packet(32) + TAIL.
  localparam logic [LEN_W:0] FIT_ISLAND = (LEN_W+1)'(44 + TAIL);
  // Next-packet fit evaluated one cycle before pkt_ctr=31, so one extra
  // cycle of remaining blank is required (34+TAIL at pkt_ctr=31).
  localparam logic [LEN_W:0] FIT_NEXT   = (LEN_W+1)'(35 + TAIL);
  localparam logic [4:0]     MAX_PK     = 5'(MAX_PACKETS);

  typedef enum logic [2:0] {
    IDLE, LEADIN, PREAMBLE, GUARD_L, PACKET, GUARD_T, DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       pkt_ctr;

  logic             start_fire;
  logic [LEN_W-1:0] rem_now;
  logic             island_fit;
  logic             next_fit;

  // blank_start is only honoured between islands; rem_now is the remaining
  // blank count for the current cycle (blank_len-1 on blank cycle 0).
  assign start_fire = blank_start && (state == IDLE || state == DONE);
  assign rem_now    = start_fire ? ((blank_len == '0) ? '0 : blank_len - LEN_W'(1))
                                 : rem_q;
  assign island_fit = packet_pending && ({1'b0, rem_now} >= FIT_ISLAND);
  assign next_fit   = packet_pending && (packet_count < MAX_PK) &&
                      ({1'b0, rem_now} >= FIT_NEXT);

  // Remaining-blank down counter, saturating at zero.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) rem_q <= '0;
    else        rem_q <= (rem_now == '0) ? '0 : rem_now - LEN_W'(1);
  end

  // Island sequencer; every output is a register set one cycle ahead.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      cnt                <= '0;
      pkt_ctr            <= '0;
      packet_pop         <= 1'b0;
      island_preamble    <= 1'b0;
      island_guard       <= 1'b0;
      data_island_period <= 1'b0;
      packet_count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (blank_start) begin
            packet_count <= '0;
            if (LEAD == 1) begin
              cnt <= '0;
              if (island_fit) begin
                state           <= PREAMBLE;
                island_preamble <= 1'b1;
              end else begin
                state <= DONE;
              end
            end else begin
              state <= LEADIN;
              cnt   <= CNT_W'(1);
            end
          end else if (state == DONE && rem_now == '0) begin
            state <= IDLE;
          end
        end
        LEADIN: begin
          if (cnt == CNT_W'(LEAD - 1)) begin
            cnt <= '0;
            if (island_fit) begin
              state           <= PREAMBLE;
              island_preamble <= 1'b1;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PREAMBLE: begin
          if (cnt == CNT_W'(7)) begin
            state           <= GUARD_L;
            cnt             <= '0;
            island_preamble <= 1'b0;
            island_guard    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GUARD_L: begin
          if (cnt == '0) begin
            // Pop lands on the second guard cycle.
            cnt        <= CNT_W'(1);
            packet_pop <= 1'b1;
          end else begin
            state              <= PACKET;
            pkt_ctr            <= '0;
            packet_pop         <= 1'b0;
            island_guard       <= 1'b0;
            data_island_period <= 1'b1;
          end
        end
        PACKET: begin
          pkt_ctr <= pkt_ctr + 5'd1;
          if (pkt_ctr == 5'd0)  packet_count <= packet_count + 5'd1;
          // Continuation is decided here so the pop is visible on pkt_ctr=31.
          if (pkt_ctr == 5'd30) packet_pop <= next_fit;
          if (pkt_ctr == 5'd31) begin
            packet_pop <= 1'b0;
            if (!packet_pop) begin
              state              <= GUARD_T;
              cnt                <= '0;
              data_island_period <= 1'b0;
              island_guard       <= 1'b1;
            end
          end
        end
        GUARD_T: begin
          if (cnt == '0) begin
            cnt <= CNT_W'(1);
          end else begin
            state        <= DONE;
            island_guard <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench: per-line expected output vectors come from a cycle model
// of the island layout and are queued, then popped and compared every cycle.
module tb_data_island_scheduler;

  localparam int LEAD  = 4;
  localparam int TAIL  = 22;
  localparam int MAXP  = 18;
  localparam int LEN_W = 12;
  localparam int NEVER = 1 << 20;

  logic             clk_pixel = 1'b0;
  logic             reset = 1'b0;
  logic             blank_start = 1'b0;
  logic [LEN_W-1:0] blank_len = '0;
  logic             packet_pending = 1'b1;
  logic             packet_pop;
  logic             island_preamble;
  logic             island_guard;
  logic             data_island_period;
  logic [4:0]       packet_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  data_island_scheduler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .blank_start        (blank_start),
    .blank_len          (blank_len),
    .packet_pending     (packet_pending),
    .packet_pop         (packet_pop),
    .island_preamble    (island_preamble),
    .island_guard       (island_guard),
    .data_island_period (data_island_period),
    .packet_count       (packet_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packets expected in a line; pending is high on cycles below drop_at.
  function automatic int npk(input int len, input int drop_at);
    int n;
    if (len < LEAD + 44 + TAIL) return 0;
    n = 1;
    while (n < MAXP && (len - 1 - (LEAD + 9 + 32*n)) >= 34 + TAIL &&
           (LEAD + 9 + 32*n) < drop_at)
      n++;
    return n;
  endfunction

  // Expected {preamble, guard, period, pop} on blank cycle c.
  function automatic logic [3:0] exp_vec(input int c, input int n);
    logic pre, g, dip, pop;
    int   end_pk;
    if (n == 0) return 4'b0;
    end_pk = LEAD + 10 + 32*n;
    pre = (c >= LEAD) && (c < LEAD + 8);
    g   = ((c >= LEAD + 8) && (c < LEAD + 10)) || ((c >= end_pk) && (c < end_pk + 2));
    dip = (c >= LEAD + 10) && (c < end_pk);
    pop = (c == LEAD + 9);
    for (int k = 1; k < n; k++) if (c == LEAD + 9 + 32*k) pop = 1'b1;
    return {pre, g, dip, pop};
  endfunction

  task automatic run_line(input int len, input int drop_at, input int stop_at);
    int n, pops, dips;
    logic [3:0] e;
    n = npk(len, drop_at);
    pops = 0;
    dips = 0;
    for (int c = 0; c < stop_at; c++) sb.push_back(exp_vec(c, n));
    for (int c = 0; c < stop_at; c++) begin
      @(posedge clk_pixel); #1;
      blank_start    = (c == 0);
      blank_len      = LEN_W'(len);
      packet_pending = (c < drop_at);
      @(negedge clk_pixel);
      e = sb.pop_front();
      check($sformatf("len%0d c%0d vec", len, c),
            {12'b0, island_preamble, island_guard, data_island_period, packet_pop},
            {12'b0, e});
      pops += int'(packet_pop);
      dips += int'(data_island_period);
    end
    if (stop_at == len) begin
      check($sformatf("len%0d count", len), {11'b0, packet_count}, 16'(n));
      check($sformatf("len%0d pops", len), 16'(pops), 16'(n));
      check($sformatf("len%0d period", len), 16'(dips), 16'(32*n));
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) sb.push_back(4'b0);
    for (int c = 0; c < k; c++) begin
      @(posedge clk_pixel); #1;
      blank_start    = 1'b0;
      packet_pending = 1'b1;
      @(negedge clk_pixel);
      check("idle vec",
            {12'b0, island_preamble, island_guard, data_island_period, packet_pop},
            {12'b0, sb.pop_front()});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset outs", {12'b0, island_preamble, island_guard, data_island_period, packet_pop}, 16'h0);
    check("reset count", {11'b0, packet_count}, 16'h0);
    @(posedge clk_pixel); #1 reset = 1'b1;
    idle(2);

    run_line(70, NEVER, 70);    idle(3);  // one packet
    run_line(69, NEVER, 69);    idle(3);  // one cycle short: no island
    run_line(102, NEVER, 102);  idle(3);  // two back-to-back packets
    run_line(4095, NEVER, 4095); idle(3); // saturates at MAX_PACKETS
    run_line(200, 34, 200);     idle(3);  // pending drops mid packet 1

    // Reset on packet cycle 10 (blank cycle 24), then replay line of 70.
    run_line(70, NEVER, 25);
    #1 reset = 1'b0;
    #1 check("async reset outs",
             {12'b0, island_preamble, island_guard, data_island_period, packet_pop}, 16'h0);
    check("async reset count", {11'b0, packet_count}, 16'h0);
    repeat (2) @(posedge clk_pixel);
    #1 reset = 1'b1;
    idle(3);
    run_line(70, NEVER, 70);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
